// File: rtl/booth_div_seq_if.sv
// Divider handshake bundle: start/operands from the control unit, busy/done/results back.
// Latency: n/a (wires only).
// Backpressure: none; start is only honoured while the divider is idle.
interface booth_div_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/booth_div_seq.sv
// Sequential signed divider (restoring, radix-2 on magnitudes); quotient -> LO, remainder -> HI.
// Latency: done WIDTH+2 cycles after the accepting edge, 1 cycle for divide-by-zero.
// Backpressure: start outside IDLE is dropped, not queued; results hold until next accepted start.
module booth_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    booth_div_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               sign_q;
    logic               sign_r;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH-1:0]   d_reg;
    logic [WIDTH:0]     p_reg;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   quotient_r;
    logic [WIDTH-1:0]   remainder_r;
    logic               div_zero_r;

    logic [WIDTH-1:0]   dvd_abs;
    logic [WIDTH-1:0]   dvs_abs;
    logic               dvs_is_zero;
    logic [WIDTH+1:0]   p_sh;
    logic [WIDTH+1:0]   trial;

    // Magnitudes are unsigned, so the most negative operand maps to 2^(WIDTH-1).
    assign dvd_abs     = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign dvs_abs     = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    assign dvs_is_zero = (bus.divisor == '0);

    assign p_sh  = {p_reg, q_reg[WIDTH-1]};
    assign trial = p_sh - {2'b00, d_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = dvs_is_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            q_reg       <= '0;
            d_reg       <= '0;
            p_reg       <= '0;
            cnt         <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            div_zero_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sign_q     <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        sign_r     <= bus.dividend[WIDTH-1];
                        q_reg      <= dvd_abs;
                        d_reg      <= dvs_abs;
                        p_reg      <= '0;
                        cnt        <= CNT_W'(WIDTH - 1);
                        div_zero_r <= dvs_is_zero;
                        if (dvs_is_zero) begin
                            quotient_r  <= '1;
                            remainder_r <= bus.dividend;
                        end
                    end
                end
                CALC: begin
                    // A negative trial (top bit set) restores the shifted remainder.
                    q_reg <= {q_reg[WIDTH-2:0], ~trial[WIDTH+1]};
                    p_reg <= trial[WIDTH+1] ? p_sh[WIDTH:0] : trial[WIDTH:0];
                    cnt   <= cnt - CNT_W'(1);
                end
                FIX: begin
                    quotient_r  <= sign_q ? -q_reg : q_reg;
                    remainder_r <= sign_r ? -p_reg[WIDTH-1:0] : p_reg[WIDTH-1:0];
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy      = (state == CALC) || (state == FIX);
    assign bus.done      = (state == DONE);
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.div_zero  = div_zero_r;
endmodule

// File: tb/tb_booth_div_seq.sv
// Directed bench for booth_div_seq: vector table plus start-while-busy and mid-run reset sequences.
module tb_booth_div_seq;
    logic clk;
    logic rst;

    booth_div_seq_if #(.WIDTH(32)) bus ();

    booth_div_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        logic        exp_dz;
        int          exp_lat;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge where done is seen.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int glitch_at,
                         output int lat, output logic seen, output logic busy1);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.dividend = 32'hDEADBEEF;
        bus.divisor  = 32'h00001234;
        lat   = 0;
        seen  = 1'b0;
        busy1 = bus.busy;
        for (int c = 1; c <= 60 && !seen; c++) begin
            if (bus.done) begin
                seen = 1'b1;
                lat  = c;
            end else begin
                if (c == glitch_at) begin
                    bus.start    = 1'b1;
                    bus.dividend = 32'd9;
                    bus.divisor  = 32'd2;
                end else if (c == glitch_at + 1) begin
                    bus.start = 1'b0;
                end
                @(posedge clk); #1;
            end
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int   lat;
        logic seen;
        logic busy1;
        logic saw_done;

        vecs[0]  = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 34};
        vecs[1]  = '{-32'sd100,    32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34};
        vecs[2]  = '{32'd100,      -32'sd7,      32'hFFFFFFF2, 32'd2,        1'b0, 34};
        vecs[3]  = '{-32'sd100,    -32'sd7,      32'd14,       32'hFFFFFFFE, 1'b0, 34};
        vecs[4]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 34};
        vecs[5]  = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0,        1'b0, 34};
        vecs[6]  = '{32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 1};
        vecs[7]  = '{32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 34};
        vecs[8]  = '{32'd3,        32'd10,       32'd0,        32'd3,        1'b0, 34};
        vecs[9]  = '{32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0, 34};
        vecs[10] = '{32'h80000000, 32'd2,        32'hC0000000, 32'd0,        1'b0, 34};
        vecs[11] = '{-32'sd7,      32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1};
        vecs[12] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 34};
        vecs[13] = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF, 1'b0, 34};
        vecs[14] = '{32'h80000000, 32'h80000000, 32'd1,        32'd0,        1'b0, 34};

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",     {31'd0, bus.busy},     32'd0);
        chk("reset_done",     {31'd0, bus.done},     32'd0);
        chk("reset_quotient", bus.quotient,          32'd0);
        chk("reset_remainder", bus.remainder,        32'd0);
        chk("reset_div_zero", {31'd0, bus.div_zero}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            do_op(vecs[i].dvd, vecs[i].dvs, 0, lat, seen, busy1);
            chk($sformatf("v%0d_done_seen", i), {31'd0, seen}, 32'd1);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_busy_c1", i), {31'd0, busy1}, {31'd0, ~vecs[i].exp_dz});
            chk($sformatf("v%0d_busy_at_done", i), {31'd0, bus.busy}, 32'd0);
            chk($sformatf("v%0d_quotient", i), bus.quotient, vecs[i].exp_q);
            chk($sformatf("v%0d_remainder", i), bus.remainder, vecs[i].exp_r);
            chk($sformatf("v%0d_div_zero", i), {31'd0, bus.div_zero}, {31'd0, vecs[i].exp_dz});
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", i), {31'd0, bus.done}, 32'd0);
            chk($sformatf("v%0d_q_hold", i), bus.quotient, vecs[i].exp_q);
            chk($sformatf("v%0d_r_hold", i), bus.remainder, vecs[i].exp_r);
        end

        // start during CALC is dropped, operands are not re-latched
        do_op(32'd100, 32'd7, 10, lat, seen, busy1);
        chk("glitch_done_seen", {31'd0, seen}, 32'd1);
        chk("glitch_latency",   lat,           32'd34);
        chk("glitch_quotient",  bus.quotient,  32'd14);
        chk("glitch_remainder", bus.remainder, 32'd2);

        // start raised in the DONE cycle is dropped too
        bus.start    = 1'b1;
        bus.dividend = 32'd1;
        bus.divisor  = 32'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("done_start_busy", {31'd0, bus.busy}, 32'd0);
        chk("done_start_done", {31'd0, bus.done}, 32'd0);
        @(posedge clk); #1;
        chk("done_start_idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("done_start_q_hold",    bus.quotient,      32'd14);

        // reset in CALC cycle 20 aborts with no done
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_busy",      {31'd0, bus.busy},     32'd0);
        chk("rst_done",      {31'd0, bus.done},     32'd0);
        chk("rst_quotient",  bus.quotient,          32'd0);
        chk("rst_remainder", bus.remainder,         32'd0);
        chk("rst_div_zero",  {31'd0, bus.div_zero}, 32'd0);
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        chk("rst_no_done", {31'd0, saw_done}, 32'd0);

        do_op(32'd9, 32'd2, 0, lat, seen, busy1);
        chk("post_rst_done_seen", {31'd0, seen}, 32'd1);
        chk("post_rst_latency",   lat,           32'd34);
        chk("post_rst_quotient",  bus.quotient,  32'd4);
        chk("post_rst_remainder", bus.remainder, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
